rob_retire_ctrl: RTL
====================

# rob_retire_ctrl

Retire/commit sequencer that sits at the head of the reorder buffer. Each cycle it decides whether the head entry retires, pops it, writes the retirement RAT (R-RAT), returns the superseded physical register to the free list, and, on a retiring mispredicted branch, runs the pipeline flush and issues the fetch redirect.

## Interface
Parameters:
- NUM_ARCH_REGS, 32, architectural register count; register 0 is hard-wired zero.
- NUM_PHYS_REGS, 64, physical register count.
- FLUSH_CYCLES, 2, cycles Flush_OUT is held (≥1).

Ports:
- CLK  in  1  clock. One clock domain; rising edge.
- RESET  in  1  asynchronous reset, active-high.
- Head_valid_IN  in  1  ROB is non-empty and the head entry is presented.
- Head_ready_IN  in  1  head entry has completed execution.
- Head_regupdate_IN  in  1  head entry writes a destination register.
- Head_arch_IN  in  log2(NUM_ARCH_REGS)  head destination architectural register.
- Head_phys_IN  in  log2(NUM_PHYS_REGS)  head destination physical register.
- Head_mispredict_IN  in  1  head is a mispredicted control instruction.
- Head_alt_pc_IN  in  32  correct target PC of the head.
- RRAT_old_phys_IN  in  log2(NUM_PHYS_REGS)  combinational R-RAT read of Head_arch_IN.
- Pop_OUT  out  1  combinational; pops the ROB head at this edge.
- RRAT_we_OUT, RRAT_arch_OUT, RRAT_phys_OUT  out  1 / log2(NUM_ARCH_REGS) / log2(NUM_PHYS_REGS)  registered R-RAT write.
- Free_valid_OUT, Free_phys_OUT  out  1 / log2(NUM_PHYS_REGS)  registered free-list return.
- Flush_OUT  out  1  registered; clears ROB, RS and rename state.
- Redirect_valid_OUT, Redirect_PC_OUT  out  1 / 32  registered one-cycle fetch redirect.
- Retired_count_OUT  out  32  instructions retired since reset.

## Operation
- States: RUN, FLUSH, REDIRECT. Reset → RUN.
- RUN: Pop_OUT = Head_valid_IN & Head_ready_IN. There is no other gating, and the rate is at most one retirement per cycle.
- On a pop with Head_regupdate_IN=1 and Head_arch_IN≠0:
  - Next cycle: RRAT_we_OUT=1, RRAT_arch_OUT=Head_arch_IN, RRAT_phys_OUT=Head_phys_IN.
  - Next cycle: Free_valid_OUT=1, Free_phys_OUT=old mapping.
- On a pop with Head_regupdate_IN=1 and Head_arch_IN=0: no R-RAT write. Next cycle Free_valid_OUT=1, Free_phys_OUT=Head_phys_IN.
- Old mapping bypass: if the registered R-RAT write is pending this cycle (RRAT_we_OUT=1) and RRAT_arch_OUT equals Head_arch_IN, the old mapping is RRAT_phys_OUT. Otherwise it is RRAT_old_phys_IN.
- Every pop increments Retired_count_OUT, wrapping modulo 2^32.
- Pop with Head_mispredict_IN=1:
  - The branch itself retires normally.
  - Head_alt_pc_IN is latched.
  - FSM → FLUSH.
- FLUSH:
  - Flush_OUT=1 for exactly FLUSH_CYCLES cycles; a down-counter with width log2(FLUSH_CYCLES)+1 times it.
  - Pop_OUT forced 0 regardless of head inputs.
  - On expiry → REDIRECT.
- REDIRECT: Redirect_valid_OUT=1 with the latched PC for one cycle; Pop_OUT=0. → RUN.
- Head inputs are ignored outside RUN.

## Timing
- Reset values: every output 0. Counter, latched PC and FSM are cleared.
- RESET asserted mid-flush or mid-redirect: abort immediately; outputs 0 asynchronously. First pop is possible the first cycle after deassertion.
- Pop latency: 0 (combinational, same cycle as head ready).
- R-RAT write and free latency: 1 cycle after the pop edge.
- Mispredict pop at edge T:
  - Flush_OUT high in cycles T+1 … T+FLUSH_CYCLES.
  - Redirect_valid_OUT high in cycle T+FLUSH_CYCLES+1.
  - Next possible pop in cycle T+FLUSH_CYCLES+2.
- Back-to-back retires to the same arch register: the second frees the first's phys via the bypass, never the stale R-RAT value.
- Head_valid_IN=0 with Head_ready_IN=1: no pop. Undriven or X ready with valid=0 must not cause a pop.
- Mispredict with Head_regupdate_IN=1 (JAL-type): R-RAT write, free, and Flush_OUT all assert in cycle T+1.

## Structure
- A shared package/config header holds:
  - FSM state encodings (RUN=0, FLUSH=1, REDIRECT=2).
  - Register-index widths derived from PROJ_NUM_ARCH_REGS / PROJ_NUM_PHYS_REGS.
  - ROB entry field offsets, so the ROB and this block agree on fields.
- One natural sub-module, `retire_flush_timer`: a loadable down-counter with a done pulse, driving FLUSH→REDIRECT.
- The rest stays flat.

## Test plan
- Reset then head valid+ready, arch=5, phys=40, old=7 → Pop_OUT=1 same cycle. Next cycle: RRAT_we=1 (5→40), Free_valid=1 with phys 7, Retired_count=1.
- Two consecutive retires: arch=3/phys=20, then arch=3/phys=21, with R-RAT still reading 9 → frees 9, then 20 (bypass).
- Retire with arch=0, phys=33, regupdate=1 → no RRAT_we; Free_phys=33.
- Mispredict retire, alt PC 0x0040_0100, FLUSH_CYCLES=2 → Flush high 2 cycles, then Redirect_valid=1 with PC 0x0040_0100 for 1 cycle. No pop while the head is held valid+ready during those 3 cycles.
- RESET asserted in the first FLUSH cycle → all outputs 0 at once. After release, a ready head pops in the next cycle and Retired_count restarts from 0.
- Preload Retired_count near 0xFFFF_FFFF via 2^32−1 pops (forced) plus one more pop → wraps to 0.

Source files
------------

// File: rtl/rob_retire_ctrl_pkg.sv
// Shared configuration for the retire sequencer: register-index widths, FSM encoding
// and the ROB entry field layout so the ROB and the retire logic agree on fields.
package rob_retire_ctrl_pkg;

  localparam int PROJ_NUM_ARCH_REGS = 32;
  localparam int PROJ_NUM_PHYS_REGS = 64;
  localparam int ARCH_W             = $clog2(PROJ_NUM_ARCH_REGS);
  localparam int PHYS_W             = $clog2(PROJ_NUM_PHYS_REGS);
  localparam int PC_W               = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } retire_state_e;

  // ROB entry layout, LSB first
  localparam int ROB_VALID_BIT   = 0;
  localparam int ROB_READY_BIT   = 1;
  localparam int ROB_REGUPD_BIT  = 2;
  localparam int ROB_MISPRED_BIT = 3;
  localparam int ROB_ARCH_LSB    = 4;
  localparam int ROB_PHYS_LSB    = ROB_ARCH_LSB + ARCH_W;
  localparam int ROB_ALTPC_LSB   = ROB_PHYS_LSB + PHYS_W;
  localparam int ROB_ENTRY_W     = ROB_ALTPC_LSB + PC_W;

  function automatic int flush_timer_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/rob_retire_ctrl_if.sv
// Head-of-ROB, R-RAT, free-list, flush and redirect signals of the retire sequencer.
// The master side is the retire controller; the slave side is the surrounding core.
interface rob_retire_ctrl_if
  import rob_retire_ctrl_pkg::*;
#(
  parameter int NUM_ARCH_REGS = PROJ_NUM_ARCH_REGS,
  parameter int NUM_PHYS_REGS = PROJ_NUM_PHYS_REGS
);

  localparam int AW = $clog2(NUM_ARCH_REGS);
  localparam int PW = $clog2(NUM_PHYS_REGS);

  logic            Head_valid_IN;
  logic            Head_ready_IN;
  logic            Head_regupdate_IN;
  logic [AW-1:0]   Head_arch_IN;
  logic [PW-1:0]   Head_phys_IN;
  logic            Head_mispredict_IN;
  logic [PC_W-1:0] Head_alt_pc_IN;
  logic [PW-1:0]   RRAT_old_phys_IN;

  logic            Pop_OUT;
  logic            RRAT_we_OUT;
  logic [AW-1:0]   RRAT_arch_OUT;
  logic [PW-1:0]   RRAT_phys_OUT;
  logic            Free_valid_OUT;
  logic [PW-1:0]   Free_phys_OUT;
  logic            Flush_OUT;
  logic            Redirect_valid_OUT;
  logic [PC_W-1:0] Redirect_PC_OUT;
  logic [31:0]     Retired_count_OUT;

  modport master (
    input  Head_valid_IN, Head_ready_IN, Head_regupdate_IN, Head_arch_IN,
           Head_phys_IN, Head_mispredict_IN, Head_alt_pc_IN, RRAT_old_phys_IN,
    output Pop_OUT, RRAT_we_OUT, RRAT_arch_OUT, RRAT_phys_OUT, Free_valid_OUT,
           Free_phys_OUT, Flush_OUT, Redirect_valid_OUT, Redirect_PC_OUT,
           Retired_count_OUT
  );

  modport slave (
    output Head_valid_IN, Head_ready_IN, Head_regupdate_IN, Head_arch_IN,
           Head_phys_IN, Head_mispredict_IN, Head_alt_pc_IN, RRAT_old_phys_IN,
    input  Pop_OUT, RRAT_we_OUT, RRAT_arch_OUT, RRAT_phys_OUT, Free_valid_OUT,
           Free_phys_OUT, Flush_OUT, Redirect_valid_OUT, Redirect_PC_OUT,
           Retired_count_OUT
  );

endinterface

// File: rtl/rob_retire_ctrl_flush_timer.sv
// Loadable down-counter that times the pipeline flush; done pulses in the last
// enabled cycle so the sequencer can leave FLUSH on that edge.
module retire_flush_timer
  import rob_retire_ctrl_pkg::*;
#(
  parameter int CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic done
);

  localparam int W = flush_timer_width(CYCLES);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = W'(CYCLES);
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = enable && (count_q == W'(1));

endmodule

// File: rtl/rob_retire_ctrl.sv
// Retire sequencer at the ROB head: pops completed entries, commits the R-RAT,
// frees superseded physical registers and runs flush/redirect on a mispredict.
module rob_retire_ctrl
  import rob_retire_ctrl_pkg::*;
#(
  parameter int NUM_ARCH_REGS = PROJ_NUM_ARCH_REGS,
  parameter int NUM_PHYS_REGS = PROJ_NUM_PHYS_REGS,
  parameter int FLUSH_CYCLES  = 2
) (
  input logic CLK,
  input logic RESET,
  rob_retire_ctrl_if.master bus
);

  localparam int AW = $clog2(NUM_ARCH_REGS);
  localparam int PW = $clog2(NUM_PHYS_REGS);

  retire_state_e   state_q, state_d;
  logic            pop, mis_pop, timer_done;
  logic [PW-1:0]   old_map;

  logic            rrat_we_q, rrat_we_d;
  logic [AW-1:0]   rrat_arch_q, rrat_arch_d;
  logic [PW-1:0]   rrat_phys_q, rrat_phys_d;
  logic            free_valid_q, free_valid_d;
  logic [PW-1:0]   free_phys_q, free_phys_d;
  logic            flush_q, flush_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [PC_W-1:0] alt_pc_q, alt_pc_d;
  logic [31:0]     retired_count_q, retired_count_d;

  retire_flush_timer #(.CYCLES(FLUSH_CYCLES)) u_flush_timer (
    .clk    (CLK),
    .rst    (RESET),
    .load   (mis_pop),
    .enable (state_q == FLUSH),
    .done   (timer_done)
  );

  // Pop is gated by reset too so every output reads 0 while reset is held
  always_comb begin
    pop     = !RESET && (state_q == RUN) && bus.Head_valid_IN && bus.Head_ready_IN;
    mis_pop = pop && bus.Head_mispredict_IN;
    state_d = state_q;
    case (state_q)
      RUN:      if (mis_pop)    state_d = FLUSH;
      FLUSH:    if (timer_done) state_d = REDIRECT;
      REDIRECT:                 state_d = RUN;
      default:                  state_d = RUN;
    endcase
  end

  // The R-RAT write from the previous retire is not yet visible in the R-RAT read port
  always_comb begin
    old_map = (rrat_we_q && (rrat_arch_q == bus.Head_arch_IN)) ? rrat_phys_q
                                                               : bus.RRAT_old_phys_IN;
    rrat_we_d    = 1'b0;
    rrat_arch_d  = '0;
    rrat_phys_d  = '0;
    free_valid_d = 1'b0;
    free_phys_d  = '0;
    if (pop && bus.Head_regupdate_IN) begin
      free_valid_d = 1'b1;
      if (bus.Head_arch_IN != '0) begin
        rrat_we_d   = 1'b1;
        rrat_arch_d = bus.Head_arch_IN;
        rrat_phys_d = bus.Head_phys_IN;
        free_phys_d = old_map;
      end else begin
        free_phys_d = bus.Head_phys_IN;
      end
    end
    retired_count_d  = retired_count_q + {31'd0, pop};
    alt_pc_d         = mis_pop ? bus.Head_alt_pc_IN : alt_pc_q;
    flush_d          = (state_d == FLUSH);
    redirect_valid_d = (state_d == REDIRECT);
    redirect_pc_d    = (state_d == REDIRECT) ? alt_pc_q : '0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q          <= RUN;
      rrat_we_q        <= 1'b0;
      rrat_arch_q      <= '0;
      rrat_phys_q      <= '0;
      free_valid_q     <= 1'b0;
      free_phys_q      <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      alt_pc_q         <= '0;
      retired_count_q  <= '0;
    end else begin
      state_q          <= state_d;
      rrat_we_q        <= rrat_we_d;
      rrat_arch_q      <= rrat_arch_d;
      rrat_phys_q      <= rrat_phys_d;
      free_valid_q     <= free_valid_d;
      free_phys_q      <= free_phys_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      alt_pc_q         <= alt_pc_d;
      retired_count_q  <= retired_count_d;
    end
  end

  assign bus.Pop_OUT            = pop;
  assign bus.RRAT_we_OUT        = rrat_we_q;
  assign bus.RRAT_arch_OUT      = rrat_arch_q;
  assign bus.RRAT_phys_OUT      = rrat_phys_q;
  assign bus.Free_valid_OUT     = free_valid_q;
  assign bus.Free_phys_OUT      = free_phys_q;
  assign bus.Flush_OUT          = flush_q;
  assign bus.Redirect_valid_OUT = redirect_valid_q;
  assign bus.Redirect_PC_OUT    = redirect_pc_q;
  assign bus.Retired_count_OUT  = retired_count_q;

endmodule
